// File: rtl/dmem_bist.sv
// Built-in self-test for dmem: writes rev(addr) everywhere, then reads back
// in bit-reversed order and counts mismatches.
module dmem_bist #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic [15:0]       mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [15:0]       first_err_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] i_nx;
    logic [ADDR_W-1:0] exp_q;
    logic [15:0]       cmp_addr;
    logic              cmp_vld;

    function automatic logic [ADDR_W-1:0] rev(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        for (int b = 0; b < ADDR_W; b++) r[b] = x[ADDR_W-1-b];
        return r;
    endfunction

    function automatic logic [15:0] a16(input logic [ADDR_W-1:0] x);
        logic [15:0] r;
        r = '0;
        r[ADDR_W-1:0] = x;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] dext(input logic [ADDR_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        r[ADDR_W-1:0] = x;
        return r;
    endfunction

    assign i_nx = i + 1'b1;

    // Outputs are registered with the values of the cycle being entered,
    // so every port change lines up with the state transition edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            i              <= '0;
            exp_q          <= '0;
            cmp_addr       <= '0;
            cmp_vld        <= 1'b0;
            mem_address    <= 16'hFFFF;
            mem_data       <= '1;
            mem_wren       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= 16'hFFFF;
        end else begin
            done    <= 1'b0;
            cmp_vld <= 1'b0;
            if (cmp_vld && (mem_q != dext(exp_q))) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_addr <= cmp_addr;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_WRITE;
                        i              <= '0;
                        busy           <= 1'b1;
                        mem_wren       <= 1'b1;
                        mem_address    <= a16('0);
                        mem_data       <= dext(rev('0));
                        err_count      <= '0;
                        pass           <= 1'b0;
                        first_err_addr <= 16'hFFFF;
                    end
                end
                S_WRITE: begin
                    if (&i) begin
                        state       <= S_READ;
                        i           <= '0;
                        mem_wren    <= 1'b0;
                        mem_data    <= '1;
                        mem_address <= a16(rev('0));
                        cmp_addr    <= a16(rev('0));
                        exp_q       <= '0;
                        cmp_vld     <= 1'b1;
                    end else begin
                        i           <= i_nx;
                        mem_address <= a16(i_nx);
                        mem_data    <= dext(rev(i_nx));
                    end
                end
                S_READ: begin
                    if (&i) begin
                        state       <= S_DRAIN;
                        mem_address <= 16'hFFFF;
                    end else begin
                        i           <= i_nx;
                        mem_address <= a16(rev(i_nx));
                        cmp_addr    <= a16(rev(i_nx));
                        exp_q       <= i_nx;
                        cmp_vld     <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bist.sv
// Directed bench for dmem_bist with a negedge-clocked dmem model
// supporting a single-bit fault and stuck-at-zero reads.
module tb_dmem_bist;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic        busy;
    logic        done;
    logic        pass;
    logic [8:0]  err_count;
    logic [15:0] first_err_addr;

    logic [15:0] mem [256];
    logic [15:0] q_r;
    logic        fault;
    logic        stuck;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_bist #(.ADDR_W(8), .DATA_W(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_wren(mem_wren),
        .mem_q(mem_q),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mem_wren) begin
            if (fault && mem_address[7:0] == 8'h40)
                mem[mem_address[7:0]] <= mem_data ^ 16'h0001;
            else
                mem[mem_address[7:0]] <= mem_data;
            wr_cnt <= wr_cnt + 1;
        end
        q_r <= mem[mem_address[7:0]];
    end

    assign mem_q = stuck ? 16'h0000 : q_r;

    always @(posedge CLK) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call just after a posedge; returns edges from start sample to done.
    task automatic run(input bit hold, input bit poke, output int cyc);
        start = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge CLK); #1;
            cyc++;
            if (!hold && cyc == 1) start = 1'b0;
            if (poke && (cyc == 100 || cyc == 400)) start = 1'b1;
            if (poke && (cyc == 101 || cyc == 401)) start = 1'b0;
            if (cyc == 1) chk("busy_rise", busy, 1);
            if (cyc == 513) chk("busy_drain", busy, 1);
            if (done) break;
            if (cyc >= 1200) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        chk("busy_at_done", busy, 0);
        @(posedge CLK); #1;
        chk("done_1cyc", done, 0);
    endtask

    initial begin
        int cyc;
        int w0;
        int d0;
        RST = 1'b1;
        start = 1'b0;
        fault = 1'b0;
        stuck = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_address, 16'hFFFF);
        chk("rst_data", mem_data, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_addr, 16'hFFFF);
        RST = 1'b0;
        @(posedge CLK); #1;

        w0 = wr_cnt;
        run(1'b0, 1'b0, cyc);
        chk("clean_len", cyc, 514);
        chk("clean_writes", wr_cnt - w0, 256);
        chk("clean_m01", mem[8'h01], 16'h0080);
        chk("clean_mfe", mem[8'hFE], 16'h007F);
        chk("clean_pass", pass, 1);
        chk("clean_err", err_count, 0);
        chk("clean_first", first_err_addr, 16'hFFFF);

        fault = 1'b1;
        run(1'b0, 1'b0, cyc);
        fault = 1'b0;
        chk("fault_pass", pass, 0);
        chk("fault_err", err_count, 1);
        chk("fault_first", first_err_addr, 16'h0040);

        stuck = 1'b1;
        run(1'b0, 1'b0, cyc);
        stuck = 1'b0;
        chk("stuck_pass", pass, 0);
        chk("stuck_err", err_count, 255);
        chk("stuck_first", first_err_addr, 16'h0080);

        d0 = done_cnt;
        run(1'b0, 1'b1, cyc);
        repeat (4) @(posedge CLK);
        #1;
        chk("poke_len", cyc, 514);
        chk("poke_dones", done_cnt - d0, 1);
        chk("poke_pass", pass, 1);

        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        chk("mid_addr", mem_address, 100);
        chk("mid_wren", mem_wren, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mrst_wren", mem_wren, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_addr", mem_address, 16'hFFFF);
        chk("mrst_data", mem_data, 16'hFFFF);
        chk("mrst_pass", pass, 0);
        chk("mrst_err", err_count, 0);
        chk("mrst_first", first_err_addr, 16'hFFFF);
        RST = 1'b0;
        @(posedge CLK); #1;
        run(1'b0, 1'b0, cyc);
        chk("mrst_len", cyc, 514);
        chk("mrst_repass", pass, 1);

        fault = 1'b1;
        run(1'b1, 1'b0, cyc);
        chk("b2b_len1", cyc, 514);
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_hold_err", err_count, 1);
        fault = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("b2b_acc_busy", busy, 1);
        chk("b2b_acc_wren", mem_wren, 1);
        chk("b2b_acc_addr", mem_address, 0);
        chk("b2b_clr_err", err_count, 0);
        chk("b2b_clr_pass", pass, 0);
        chk("b2b_clr_first", first_err_addr, 16'hFFFF);
        cyc = 1;
        while (!done && cyc < 1200) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("b2b_len2", cyc, 514);
        chk("b2b_pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
